mips_mc_controller: RTL and testbench

Main control unit for the multicycle MIPS core: a Moore state machine that sequences one instruction through fetch, decode, execute, memory and writeback, driving every datapath mux select and write enable plus the `ALUControl` code of the 32-bit ALU. It sits beside the datapath and reads `Op`/`Funct` from the instruction register and the ALU `zero` flag.

---
 rtl/mips_mc_controller.sv | 184 ++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - Moore control FSM for the multicycle MIPS datapath.
// Optional macro MIPS_MC_JUMP_EN adds the JUMP state and PCSrc=10.
module mips_mc_controller #(
   parameter int ALUControl_WIDTH = 3,
   parameter int OP_WIDTH         = 6
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [OP_WIDTH-1:0]         Op,
   input  logic [OP_WIDTH-1:0]         Funct,
   input  logic                        zero,
   output logic                        IorD,
   output logic                        MemWrite,
   output logic                        IRWrite,
   output logic                        RegDst,
   output logic                        MemtoReg,
   output logic                        RegWrite,
   output logic                        ALUSrcA,
   output logic [1:0]                  ALUSrcB,
   output logic [ALUControl_WIDTH-1:0] ALUControl,
   output logic [1:0]                  PCSrc,
   output logic                        PCEn,
   output logic [3:0]                  state_o
);

   typedef enum logic [3:0] {
      S_RST      = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXECUTE  = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_ADDIEX   = 4'd10,
      S_ADDIWB   = 4'd11,
      S_JUMP     = 4'd12
   } state_t;

   localparam logic [OP_WIDTH-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_WIDTH-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_WIDTH-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_WIDTH-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_WIDTH-1:0] OP_ADDI  = 6'b001000;
`ifdef MIPS_MC_JUMP_EN
   localparam logic [OP_WIDTH-1:0] OP_J     = 6'b000010;
`endif

   localparam logic [OP_WIDTH-1:0] F_ADD = 6'b100000;
   localparam logic [OP_WIDTH-1:0] F_SUB = 6'b100010;
   localparam logic [OP_WIDTH-1:0] F_AND = 6'b100100;
   localparam logic [OP_WIDTH-1:0] F_OR  = 6'b100101;
   localparam logic [OP_WIDTH-1:0] F_SLT = 6'b101010;

   localparam logic [ALUControl_WIDTH-1:0] ALU_ADD = 3'b010;
   localparam logic [ALUControl_WIDTH-1:0] ALU_SUB = 3'b110;
   localparam logic [ALUControl_WIDTH-1:0] ALU_AND = 3'b000;
   localparam logic [ALUControl_WIDTH-1:0] ALU_OR  = 3'b001;
   localparam logic [ALUControl_WIDTH-1:0] ALU_SLT = 3'b111;

   state_t state, state_next;
   logic   pc_write, branch, pc_src_lo;
`ifdef MIPS_MC_JUMP_EN
   logic   pc_src_hi;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_RST;
      else        state <= state_next;
   end

   always_comb begin
      state_next = S_FETCH;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = '0;
      pc_src_lo  = 1'b0;
`ifdef MIPS_MC_JUMP_EN
      pc_src_hi  = 1'b0;
`endif
      pc_write   = 1'b0;
      branch     = 1'b0;
      case (state)
         S_RST: state_next = S_FETCH;
         S_FETCH: begin
            IRWrite    = 1'b1;
            ALUSrcB    = 2'b01;
            ALUControl = ALU_ADD;
            pc_write   = 1'b1;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            // Speculatively compute the branch target into ALUOut
            ALUSrcB    = 2'b11;
            ALUControl = ALU_ADD;
            case (Op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_EXECUTE;
               OP_BEQ:       state_next = S_BRANCH;
               OP_ADDI:      state_next = S_ADDIEX;
`ifdef MIPS_MC_JUMP_EN
               OP_J:         state_next = S_JUMP;
`endif
               default:      state_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUControl = ALU_ADD;
            state_next = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            IorD       = 1'b1;
            state_next = S_MEMWB;
         end
         S_MEMWB: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
         end
         S_MEMWRITE: begin
            IorD       = 1'b1;
            MemWrite   = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA    = 1'b1;
            state_next = S_ALUWB;
            case (Funct)
               F_ADD:   ALUControl = ALU_ADD;
               F_SUB:   ALUControl = ALU_SUB;
               F_AND:   ALUControl = ALU_AND;
               F_OR:    ALUControl = ALU_OR;
               F_SLT:   ALUControl = ALU_SLT;
               default: begin
                  ALUControl = ALU_ADD;
                  state_next = S_FETCH;
               end
            endcase
         end
         S_ALUWB: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            pc_src_lo  = 1'b1;
            branch     = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ALUControl = ALU_ADD;
            state_next = S_ADDIWB;
         end
         S_ADDIWB: RegWrite = 1'b1;
`ifdef MIPS_MC_JUMP_EN
         S_JUMP: begin
            pc_src_hi  = 1'b1;
            pc_write   = 1'b1;
         end
`endif
         default: state_next = S_FETCH;
      endcase
   end

`ifdef MIPS_MC_JUMP_EN
   assign PCSrc = {pc_src_hi, pc_src_lo};
`else
   assign PCSrc = {1'b0, pc_src_lo};
`endif

   assign PCEn    = pc_write | (branch & zero);
   assign state_o = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - Randomized self-checking bench for mips_mc_controller.
// Honours MIPS_MC_JUMP_EN when building its expected instruction sequences.
module tb_mips_mc_controller;

   logic       clk;
   logic       rst_n;
   logic [5:0] Op, Funct;
   logic       zero;
   logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUControl;
   logic [3:0] state_o;
   logic [14:0] obs;

   int checks = 0;
   int errors = 0;
   int seq[$];

`ifdef MIPS_MC_JUMP_EN
   localparam bit JEN = 1'b1;
`else
   localparam bit JEN = 1'b0;
`endif

   mips_mc_controller dut (
      .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .zero(zero),
      .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
      .PCEn(PCEn), .state_o(state_o)
   );

   assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, ALUControl, PCSrc, PCEn};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic logic [2:0] funct_alu(input logic [5:0] f, output bit legal);
      legal = 1'b1;
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default: begin legal = 1'b0; return 3'b010; end
      endcase
   endfunction

   // Reference: the states an instruction visits, starting at FETCH
   task automatic build_seq(input logic [5:0] op, input logic [5:0] f);
      bit legal;
      logic [2:0] unused_ac;
      seq = {1, 2};
      case (op)
         6'b100011: seq = {seq, 3, 4, 5};
         6'b101011: seq = {seq, 3, 6};
         6'b000100: seq.push_back(9);
         6'b001000: seq = {seq, 10, 11};
         6'b000010: if (JEN) seq.push_back(12);
         6'b000000: begin
            unused_ac = funct_alu(f, legal);
            seq.push_back(7);
            if (legal) seq.push_back(8);
         end
         default: ;
      endcase
   endtask

   // Reference: outputs per state, packed in the same order as obs
   function automatic logic [14:0] exp_out(input int st, input logic [5:0] f, input logic z);
      logic iord, mw, irw, rd, m2r, rw, sa, pcen;
      logic [1:0] sb, ps;
      logic [2:0] ac;
      bit legal;
      {iord, mw, irw, rd, m2r, rw, sa, pcen} = '0;
      sb = 2'b00; ps = 2'b00; ac = 3'b000;
      case (st)
         1:  begin irw = 1; sb = 2'b01; ac = 3'b010; pcen = 1; end
         2:  begin sb = 2'b11; ac = 3'b010; end
         3:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
         4:  iord = 1;
         5:  begin rw = 1; m2r = 1; end
         6:  begin iord = 1; mw = 1; end
         7:  begin sa = 1; ac = funct_alu(f, legal); end
         8:  begin rw = 1; rd = 1; end
         9:  begin sa = 1; ac = 3'b110; ps = 2'b01; pcen = z; end
         10: begin sa = 1; sb = 2'b10; ac = 3'b010; end
         11: rw = 1;
         12: begin ps = 2'b10; pcen = 1; end
         default: ;
      endcase
      return {iord, mw, irw, rd, m2r, rw, sa, sb, ac, ps, pcen};
   endfunction

   task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z);
      Op = op; Funct = f; zero = z;
      build_seq(op, f);
      foreach (seq[i]) begin
         chk($sformatf("state op=%b f=%b step%0d", op, f, i), 32'(state_o), 32'(seq[i]));
         chk($sformatf("outputs op=%b f=%b z=%0b st=%0d", op, f, z, seq[i]),
             32'(obs), 32'(exp_out(seq[i], f, z)));
         tick();
      end
      chk($sformatf("return_fetch op=%b f=%b", op, f), 32'(state_o), 32'd1);
   endtask

   logic [5:0] ops[7]    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                             6'b001000, 6'b000010, 6'b111111};
   logic [5:0] functs[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

   initial begin
      rst_n = 1'b0; Op = '0; Funct = '0; zero = 1'b0;
      #2;
      chk("reset_state_async", 32'(state_o), 32'd0);
      repeat (3) tick();
      chk("reset_state_held", 32'(state_o), 32'd0);
      chk("reset_outputs", 32'(obs), 32'd0);
      rst_n = 1'b1;
      chk("rst_state_before_edge", 32'(state_o), 32'd0);
      tick();
      chk("first_fetch_state", 32'(state_o), 32'd1);
      chk("first_fetch_irwrite", 32'(IRWrite), 32'd1);
      chk("first_fetch_pcen", 32'(PCEn), 32'd1);

      run_instr(6'b100011, 6'b000000, 1'b0);   // lw
      run_instr(6'b101011, 6'b000000, 1'b1);   // sw
      run_instr(6'b000000, 6'b100010, 1'b0);   // sub
      run_instr(6'b000000, 6'b101010, 1'b0);   // slt
      run_instr(6'b000100, 6'b000000, 1'b1);   // beq taken
      run_instr(6'b000100, 6'b000000, 1'b0);   // beq not taken
      run_instr(6'b111111, 6'b000000, 1'b0);   // illegal opcode
      run_instr(6'b000000, 6'b000111, 1'b0);   // unknown funct
      run_instr(6'b001000, 6'b000000, 1'b0);   // addi
      run_instr(6'b000010, 6'b000000, 1'b0);   // j

      for (int n = 0; n < 60; n++) begin
         logic [5:0] op, f;
         op = ops[$urandom_range(0, 6)];
         if ($urandom_range(0, 5) == 0) op = 6'($urandom);
         f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 4)];
         run_instr(op, f, 1'($urandom));
      end

      // Reset while lw sits in MEMREAD must abort before the MEMWB write
      Op = 6'b100011; Funct = '0; zero = 1'b0;
      repeat (3) tick();
      chk("midreset_in_memread", 32'(state_o), 32'd4);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset_async_state", 32'(state_o), 32'd0);
      chk("midreset_async_outputs", 32'(obs), 32'd0);
      repeat (2) begin
         tick();
         chk("midreset_held_state", 32'(state_o), 32'd0);
         chk("midreset_no_regwrite", 32'(RegWrite), 32'd0);
      end
      rst_n = 1'b1;
      tick();
      chk("midreset_refetch", 32'(state_o), 32'd1);
      run_instr(6'b100011, 6'b000000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
